pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter register and branch-resolution block for the multi-cycle CPU. It consumes the ALU zero flag produced by the 32-bit zero detector and turns it, together with the controller's PCWrite/PCWriteCond strobes, into the next PC. It sits between the control FSM, the ALU/ALUOut register and the instruction register. It also keeps saturating branch statistics for debug readout.

## Interface
- WIDTH, 32: PC/data width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- CNT_W, 16: width of the statistics counters.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_write  input  1  unconditional PC write (fetch / jump states).
- pc_write_cond  input  1  conditional PC write (branch-completion state).
- br_ne  input  1  0 = beq semantics, 1 = bne semantics; sampled with pc_write_cond.
- pc_source  input  2  next-PC select: 0 = alu_result, 1 = alu_out, 2 = jump target, 3 = RESET_PC.
- alu_result  input  WIDTH  combinational ALU output (PC+4 during fetch).
- alu_out  input  WIDTH  ALUOut register (branch target computed in decode).
- jaddr  input  26  instruction[25:0].
- zero  input  1  ALU zero flag, valid in the same cycle as pc_write_cond.
- stat_clr  input  1  synchronous clear of the statistics counters.
- pc  output  WIDTH  current PC register.
- br_taken  output  1  registered: last resolved branch was taken.
- br_cnt  output  CNT_W  branches resolved, saturating.
- br_taken_cnt  output  CNT_W  branches taken, saturating.

## Operation
- cond = zero XOR (br_ne & BNE enabled).
- pc_en = pc_write | (pc_write_cond & cond).
- next_pc mux:
  - 0 → alu_result.
  - 1 → alu_out.
  - 2 → {pc[31:28], jaddr, 2'b00}.
  - 3 → RESET_PC.
- The PC loads next_pc on the edge where pc_en = 1; otherwise it holds.
- pc_write has priority: when pc_write and pc_write_cond are both high, the PC loads unconditionally. br_cnt and br_taken still update from pc_write_cond.
- Each cycle with pc_write_cond = 1:
  - br_cnt increments by 1.
  - br_taken <= cond.
  - br_taken_cnt increments if cond = 1.
- Both counters saturate at all-ones and never wrap.
- stat_clr zeroes both counters and br_taken. It wins over a simultaneous increment but does not affect the PC.
- Resolution-tracking FSM:
  - IDLE: leaves on pc_write_cond, to TAKEN if cond = 1, else NOTTAKEN.
  - TAKEN / NOTTAKEN: last one cycle. On the next cycle they return to IDLE, or re-evaluate if pc_write_cond is high again.
  - br_taken is the registered view of this FSM.
- The PC low two bits are not forced. Alignment is the source's responsibility.

## Timing
- Reset (rst_n = 0, asynchronous): pc = RESET_PC, br_taken = 0, br_cnt = 0, br_taken_cnt = 0, FSM = IDLE. All outputs are valid while reset is asserted.
- Deassertion takes effect at the first rising edge with rst_n = 1. The first PC load can occur on that edge.
- PC latency: one edge from pc_en to the new pc value. pc is a pure register output with no combinational path from its inputs.
- br_taken and the counters update on the same edge as the PC.
- Reset mid-operation: a pending branch is discarded and the PC returns to RESET_PC immediately.
- Back-to-back pc_write_cond cycles are each counted and resolved independently.

## Configuration
- BNE_EN:
  - Defined: br_ne inverts the zero condition, giving bne support.
  - Undefined: br_ne is ignored and cond = zero (beq only). The port remains present so connections are unchanged.

## Test plan
- Reset: hold rst_n = 0 with random inputs → pc = 0x00000000 and all counters 0. Release, then pc_write = 1, pc_source = 0, alu_result = 0x4 → pc = 0x4 after one edge.
- beq taken and not taken:
  - pc = 0x10, alu_out = 0x40, pc_source = 1, pc_write_cond = 1, zero = 1 → pc = 0x40, br_taken = 1, br_cnt = 1, br_taken_cnt = 1.
  - Repeat with zero = 0 → pc stays 0x40, br_taken = 0, br_cnt = 2, br_taken_cnt = 1.
- bne: br_ne = 1, zero = 0, alu_out = 0x80:
  - With BNE_EN → pc = 0x80.
  - Without BNE_EN → pc unchanged.
- Jump: pc = 0x30000010, jaddr = 0x0000100, pc_source = 2, pc_write = 1 → pc = 0x30000400.
- Saturation and clear: with CNT_W = 4, apply 20 taken branches → br_cnt = br_taken_cnt = 0xF. Then stat_clr together with pc_write_cond → both counters 0 and br_taken = 0.
- Async reset mid-branch: drop rst_n between clock edges while pc_write_cond = 1 → pc becomes 0 immediately, before the next edge, and the counters are 0.

Source files
------------

// File: rtl/pc_branch_unit_if.sv
// rtl/pc_branch_unit_if.sv - controller-to-PC/branch-unit bundle
// The master modport belongs to the control path and the slave modport to pc_branch_unit.
interface pc_branch_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             pc_write;
  logic             pc_write_cond;
  logic             br_ne;
  logic [1:0]       pc_source;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_out;
  logic [25:0]      jaddr;
  logic             zero;
  logic             stat_clr;
  logic [WIDTH-1:0] pc;
  logic             br_taken;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] br_taken_cnt;

  modport master (
    output pc_write, pc_write_cond, br_ne, pc_source, alu_result, alu_out,
           jaddr, zero, stat_clr,
    input  pc, br_taken, br_cnt, br_taken_cnt
  );

  modport slave (
    input  pc_write, pc_write_cond, br_ne, pc_source, alu_result, alu_out,
           jaddr, zero, stat_clr,
    output pc, br_taken, br_cnt, br_taken_cnt
  );
endinterface

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC register, branch resolution and saturating branch statistics
// Define BNE_EN to let br_ne invert the zero condition (bne); otherwise only beq is resolved.
module pc_branch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_branch_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TAKEN, NOTTAKEN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             br_taken_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] br_taken_cnt_q;
  logic             cond;
  logic             pc_en;

`ifdef BNE_EN
  assign cond = bus.zero ^ bus.br_ne;
`else
  // br_ne stays on the port so the controller wiring is identical in both builds.
  logic unused_br_ne;
  assign unused_br_ne = bus.br_ne;
  assign cond = bus.zero;
`endif

  assign pc_en = bus.pc_write | (bus.pc_write_cond & cond);

  always_comb begin
    pc_d = pc_q;
    case (bus.pc_source)
      2'd0:    pc_d = bus.alu_result;
      2'd1:    pc_d = bus.alu_out;
      2'd2:    pc_d = {pc_q[WIDTH-1:28], bus.jaddr, 2'b00};
      default: pc_d = RESET_PC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      br_taken_q     <= 1'b0;
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      if (pc_en) begin
        pc_q <= pc_d;
      end

      // Every state resolves a new branch immediately, so back-to-back strobes never stall.
      case (state_q)
        IDLE, TAKEN, NOTTAKEN: begin
          if (bus.pc_write_cond) begin
            state_q <= cond ? TAKEN : NOTTAKEN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (bus.stat_clr) begin
        br_taken_q     <= 1'b0;
        br_cnt_q       <= '0;
        br_taken_cnt_q <= '0;
      end else if (bus.pc_write_cond) begin
        br_taken_q <= cond;
        if (br_cnt_q != CNT_MAX) begin
          br_cnt_q <= br_cnt_q + CNT_ONE;
        end
        if (cond && (br_taken_cnt_q != CNT_MAX)) begin
          br_taken_cnt_q <= br_taken_cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.br_taken     = br_taken_q;
  assign bus.br_cnt       = br_cnt_q;
  assign bus.br_taken_cnt = br_taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed and random checks of pc_branch_unit against a behavioural model
module tb_pc_branch_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   passes = 0;

  pc_branch_unit_if #(.WIDTH(32), .CNT_W(CNT_W)) bus ();

  pc_branch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: branch taken when zero matches the requested sense; counters are clamped integers.
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_tcnt;
  bit          m_tk;

  function automatic bit taken_now();
    return (BNE && bus.br_ne) ? !bus.zero : bus.zero;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] cur);
    case (bus.pc_source)
      2'd0:    return bus.alu_result;
      2'd1:    return bus.alu_out;
      2'd2:    return (cur & 32'hF000_0000) | ({6'd0, bus.jaddr} * 4);
      default: return 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc   <= 32'h0;
      m_cnt  <= 0;
      m_tcnt <= 0;
      m_tk   <= 1'b0;
    end else begin
      if (bus.pc_write || (bus.pc_write_cond && taken_now())) m_pc <= target(m_pc);
      if (bus.stat_clr) begin
        m_cnt  <= 0;
        m_tcnt <= 0;
        m_tk   <= 1'b0;
      end else if (bus.pc_write_cond) begin
        m_tk   <= taken_now();
        m_cnt  <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        m_tcnt <= taken_now() ? ((m_tcnt + 1 > CMAX) ? CMAX : m_tcnt + 1) : m_tcnt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc", bus.pc, m_pc);
      chk("model_br_taken", {31'd0, bus.br_taken}, {31'd0, m_tk});
      chk("model_br_cnt", {28'd0, bus.br_cnt}, m_cnt);
      chk("model_br_taken_cnt", {28'd0, bus.br_taken_cnt}, m_tcnt);
    end
  end

  task automatic drive(input bit pw, input bit pwc, input bit ne, input bit z,
                       input logic [1:0] src, input logic [31:0] ar,
                       input logic [31:0] ao, input logic [25:0] ja, input bit clr);
    bus.pc_write      = pw;
    bus.pc_write_cond = pwc;
    bus.br_ne         = ne;
    bus.zero          = z;
    bus.pc_source     = src;
    bus.alu_result    = ar;
    bus.alu_out       = ao;
    bus.jaddr         = ja;
    bus.stat_clr      = clr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom,
          26'($urandom), ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    drive(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 26'h0, 0);
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      drive_random();
    end
    @(negedge clk);
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_br_taken", {31'd0, bus.br_taken}, 32'h0);
    chk("reset_br_cnt", {28'd0, bus.br_cnt}, 32'h0);
    chk("reset_br_taken_cnt", {28'd0, bus.br_taken_cnt}, 32'h0);

    // First load lands on the first edge after release.
    drive(1, 0, 0, 0, 2'd0, 32'h4, 32'h0, 26'h0, 0);
    rst_n = 1'b1;
    step();
    chk("fetch_pc", bus.pc, 32'h4);

    drive(1, 0, 0, 0, 2'd0, 32'h10, 32'h0, 26'h0, 0);
    step();
    drive(0, 1, 0, 1, 2'd1, 32'h14, 32'h40, 26'h0, 0);
    step();
    chk("beq_taken_pc", bus.pc, 32'h40);
    chk("beq_taken_flag", {31'd0, bus.br_taken}, 32'h1);
    chk("beq_taken_cnt", {28'd0, bus.br_cnt}, 32'h1);
    chk("beq_taken_tcnt", {28'd0, bus.br_taken_cnt}, 32'h1);

    drive(0, 1, 0, 0, 2'd1, 32'h14, 32'h40, 26'h0, 0);
    step();
    chk("beq_nt_pc", bus.pc, 32'h40);
    chk("beq_nt_flag", {31'd0, bus.br_taken}, 32'h0);
    chk("beq_nt_cnt", {28'd0, bus.br_cnt}, 32'h2);
    chk("beq_nt_tcnt", {28'd0, bus.br_taken_cnt}, 32'h1);

    drive(0, 1, 1, 0, 2'd1, 32'h44, 32'h80, 26'h0, 0);
    step();
    chk("bne_pc", bus.pc, BNE ? 32'h80 : 32'h40);
    chk("bne_flag", {31'd0, bus.br_taken}, BNE ? 32'h1 : 32'h0);
    chk("bne_cnt", {28'd0, bus.br_cnt}, 32'h3);

    drive(1, 0, 0, 0, 2'd0, 32'h3000_0010, 32'h0, 26'h0, 0);
    step();
    drive(1, 0, 0, 0, 2'd2, 32'h0, 32'h0, 26'h000_0100, 0);
    step();
    chk("jump_pc", bus.pc, 32'h3000_0400);

    // Unconditional write wins over a not-taken branch, which is still counted.
    drive(1, 1, 0, 0, 2'd0, 32'h1234_5678, 32'h0, 26'h0, 0);
    step();
    chk("prio_pc", bus.pc, 32'h1234_5678);
    chk("prio_cnt", {28'd0, bus.br_cnt}, 32'h4);

    drive(0, 1, 0, 1, 2'd1, 32'h0, 32'h40, 26'h0, 0);
    repeat (20) step();
    chk("sat_cnt", {28'd0, bus.br_cnt}, 32'hF);
    chk("sat_tcnt", {28'd0, bus.br_taken_cnt}, 32'hF);

    drive(0, 1, 0, 1, 2'd1, 32'h0, 32'h40, 26'h0, 1);
    step();
    chk("clr_cnt", {28'd0, bus.br_cnt}, 32'h0);
    chk("clr_tcnt", {28'd0, bus.br_taken_cnt}, 32'h0);
    chk("clr_flag", {31'd0, bus.br_taken}, 32'h0);
    chk("clr_pc", bus.pc, 32'h40);

    repeat (60) begin
      drive_random();
      step();
    end

    drive(0, 1, 0, 1, 2'd1, 32'h0, 32'h80, 26'h0, 0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_cnt", {28'd0, bus.br_cnt}, 32'h0);
    chk("async_tcnt", {28'd0, bus.br_taken_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 26'h0, 0);
    step();
    chk("post_reset_pc", bus.pc, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
